// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise logic unit: operation codes and FSM states.
package bitwise_pkg;

    // Operation select codes carried on ctrl_op
    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_ANDN = 3'b111;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bitwise_slice.sv
// Combinational CHUNK-bit slice: applies the selected bitwise operation to a and b.
module bitwise_slice
    import bitwise_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic [2:0]       op,
    output logic [CHUNK-1:0] y
);

    // Pure per-bit logic; b is a don't-care for NOT
    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_ANDN: y = a & ~b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit: processes CHUNK bits per cycle over WIDTH/CHUNK
// cycles with a start/ready handshake, a busy flag and a registered zero flag.
module bitwise_logic_unit
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int NCYC  = WIDTH / CHUNK
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [2:0]       ctrl_op,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_isZero,
    output logic             data_resultRDY,
    output logic             busy
);

    // Counter needs at least one bit even for the single-cycle configuration
    localparam int CW = (NCYC > 1) ? $clog2(NCYC) : 1;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] a_work_reg, b_work_reg, res_work_reg;
    logic [2:0]       op_work_reg;
    logic [CHUNK-1:0] slice_y;
    logic [WIDTH-1:0] res_shift;
    logic             last_chunk;

    assign last_chunk = (count_reg == CW'(NCYC - 1));

    bitwise_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a  (a_work_reg[CHUNK-1:0]),
        .b  (b_work_reg[CHUNK-1:0]),
        .op (op_work_reg),
        .y  (slice_y)
    );

    // New chunk enters at the top so after NCYC shifts chunk 0 sits at the bottom
    generate
        if (CHUNK == WIDTH) begin : g_single
            assign res_shift = slice_y;
        end else begin : g_multi
            assign res_shift = {slice_y, res_work_reg[WIDTH-1:CHUNK]};
        end
    endgenerate

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a start in any state (re)launches an operation
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (ctrl_start) state_next = S_RUN;
            S_RUN: begin
                if (ctrl_start)      state_next = S_RUN;
                else if (last_chunk) state_next = S_DONE;
            end
            S_DONE:  state_next = ctrl_start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Moore handshake outputs, registered from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy           <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            busy           <= (state_next == S_RUN);
            data_resultRDY <= (state_next == S_DONE);
        end
    end

    // Working shift registers and counter; a start discards any in-flight work
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_work_reg   <= '0;
            b_work_reg   <= '0;
            res_work_reg <= '0;
            op_work_reg  <= OP_NOT;
            count_reg    <= '0;
        end else if (ctrl_start) begin
            a_work_reg  <= data_operandA;
            b_work_reg  <= data_operandB;
            op_work_reg <= ctrl_op;
            count_reg   <= '0;
        end else if (state_reg == S_RUN) begin
            a_work_reg   <= a_work_reg >> CHUNK;
            b_work_reg   <= b_work_reg >> CHUNK;
            res_work_reg <= res_shift;
            count_reg    <= last_chunk ? '0 : count_reg + 1'b1;
        end
    end

    // Visible result only changes on completion, never with partial values
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_result <= '0;
            data_isZero <= 1'b1;
        end else if (!ctrl_start && state_reg == S_RUN && last_chunk) begin
            data_result <= res_shift;
            data_isZero <= (res_shift == '0);
        end
    end

endmodule
